// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I subset CPU with one Avalon-style master port shared by
// instruction fetch and data access; halts when the next PC would be zero.
module mips_cpu_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, LWB, WB, HALT
    } state_t;

    state_t      state;
    logic [31:0] regs [32];
    logic [31:0] pc, instr, rs_val, rt_val;
    logic [31:0] result, br_target, pend_target;
    logic [4:0]  dest;
    logic        wen, br_taken, pend_valid, is_load;

    logic [5:0]  opcode, funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] simm, zimm, pc_plus4, ea, npc;
    logic [31:0] alu;
    logic [4:0]  wr_dst;
    logic        wr_en, taken, mem_load, mem_store;
    logic [31:0] target;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign shamt       = instr[10:6];
    assign imm         = instr[15:0];
    assign simm        = {{16{imm[15]}}, imm};
    assign zimm        = {16'h0000, imm};
    assign pc_plus4    = pc + 32'd4;
    assign ea          = rs_val + simm;
    assign npc         = pend_valid ? pend_target : pc_plus4;
    assign register_v0 = regs[2];
    assign byteenable  = 4'b1111;

    always_comb begin
        alu       = '0;
        wr_dst    = instr[15:11];
        wr_en     = 1'b0;
        taken     = 1'b0;
        target    = '0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        case (opcode)
            6'h00: begin
                wr_en = 1'b1;
                case (funct)
                    6'h21: alu = rs_val + rt_val;
                    6'h23: alu = rs_val - rt_val;
                    6'h24: alu = rs_val & rt_val;
                    6'h25: alu = rs_val | rt_val;
                    6'h26: alu = rs_val ^ rt_val;
                    6'h2A: alu = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: alu = {31'b0, rs_val < rt_val};
                    6'h00: alu = rt_val << shamt;
                    6'h02: alu = rt_val >> shamt;
                    6'h03: alu = $signed(rt_val) >>> shamt;
                    6'h08: begin
                        wr_en  = 1'b0;
                        taken  = 1'b1;
                        target = rs_val;
                    end
                    6'h09: begin
                        alu    = pc + 32'd8;
                        taken  = 1'b1;
                        target = rs_val;
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            6'h02, 6'h03: begin
                taken  = 1'b1;
                target = {pc_plus4[31:28], instr[25:0], 2'b00};
                if (opcode == 6'h03) begin
                    wr_en  = 1'b1;
                    wr_dst = 5'd31;
                    alu    = pc + 32'd8;
                end
            end
            6'h04, 6'h05: begin
                taken  = (rs_val == rt_val) ^ (opcode == 6'h05);
                target = pc_plus4 + {simm[29:0], 2'b00};
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
                wr_en  = 1'b1;
                wr_dst = instr[20:16];
                case (opcode)
                    6'h09:   alu = rs_val + simm;
                    6'h0A:   alu = {31'b0, $signed(rs_val) < $signed(simm)};
                    6'h0B:   alu = {31'b0, rs_val < simm};
                    6'h0C:   alu = rs_val & zimm;
                    6'h0D:   alu = rs_val | zimm;
                    6'h0E:   alu = rs_val ^ zimm;
                    6'h0F:   alu = {imm, 16'h0000};
                    default: mem_load = 1'b1;
                endcase
            end
            6'h2B: mem_store = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_VECTOR;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
            active      <= 1'b1;
            read        <= 1'b0;
            write       <= 1'b0;
            address     <= RESET_VECTOR;
            writedata   <= '0;
            instr       <= '0;
            rs_val      <= '0;
            rt_val      <= '0;
            result      <= '0;
            dest        <= '0;
            wen         <= 1'b0;
            br_taken    <= 1'b0;
            br_target   <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            is_load     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Request is raised one cycle after entry so outputs stay registered.
                    if (!read) begin
                        read    <= 1'b1;
                        address <= pc;
                    end else if (!waitrequest) begin
                        read  <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    instr  <= readdata;
                    rs_val <= regs[readdata[25:21]];
                    rt_val <= regs[readdata[20:16]];
                    state  <= EXEC;
                end
                EXEC: begin
                    result    <= alu;
                    dest      <= wr_dst;
                    wen       <= wr_en;
                    br_taken  <= taken;
                    br_target <= target;
                    if (mem_load || mem_store) begin
                        address   <= {ea[31:2], 2'b00};
                        read      <= mem_load;
                        write     <= mem_store;
                        writedata <= rt_val;
                        is_load   <= mem_load;
                        state     <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        state <= is_load ? LWB : WB;
                    end
                end
                LWB: begin
                    result <= readdata;
                    state  <= WB;
                end
                WB: begin
                    if (wen && dest != 5'd0) regs[dest] <= result;
                    // A taken branch redirects only after its delay slot retires.
                    pc          <= npc;
                    pend_valid  <= br_taken;
                    pend_target <= br_target;
                    if (npc == '0) begin
                        state  <= HALT;
                        active <= 1'b0;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: ;
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: bus slave with programmable wait states, directed
// programs plus randomized ALU programs checked against an ISA-level model.
module tb_mips_cpu_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    always #5 clk = ~clk;

    mips_cpu_bus #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    // Program image is written only by the initial block; bus stores land in
    // dmem, tagged with the current program generation.
    logic [31:0] mem  [256];
    logic [31:0] dmem [256];
    int unsigned dgen [256];
    int unsigned gen = 1;
    int unsigned wait_cycles = 0;
    int unsigned stall_cnt = 0;

    logic [31:0] acc_addr [$];
    logic        acc_read [$];
    int unsigned be_bad = 0, stab_err = 0, stall_seen = 0, both_err = 0, zero_fetch = 0;
    logic [31:0] last_st_addr = '0, last_st_data = '0;
    logic        hold_v = 1'b0, h_rd = 1'b0, h_wr = 1'b0;
    logic [31:0] h_addr = '0, h_wd = '0;

    int unsigned checks = 0, passes = 0;
    logic [31:0] prog [$];

    assign waitrequest = (read || write) && (stall_cnt < wait_cycles);

    function automatic int mem_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'hBFC00000;
        return (off < 32'd1024) ? int'(off[9:2]) : -1;
    endfunction

    function automatic logic [31:0] mem_view(input logic [31:0] a);
        int i;
        i = mem_idx(a);
        if (i < 0) return '0;
        return (dgen[i] == gen) ? dmem[i] : mem[i];
    endfunction

    always @(posedge clk) begin
        int i;
        if ((read || write) && waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (read && write) both_err <= both_err + 1;
        if (read && address == '0) zero_fetch <= zero_fetch + 1;
        if (hold_v && (address != h_addr || read != h_rd || write != h_wr || writedata != h_wd))
            stab_err <= stab_err + 1;
        hold_v <= (read || write) && waitrequest;
        h_addr <= address;
        h_rd   <= read;
        h_wr   <= write;
        h_wd   <= writedata;
        if ((read || write) && waitrequest) stall_seen <= stall_seen + 1;
        if ((read || write) && !waitrequest) begin
            acc_addr.push_back(address);
            acc_read.push_back(read);
            if (byteenable != 4'b1111) be_bad <= be_bad + 1;
            if (read) readdata <= mem_view(address);
            if (write) begin
                last_st_addr <= address;
                last_st_data <= writedata;
                i = mem_idx(address);
                if (i >= 0) begin
                    dmem[i] <= writedata;
                    dgen[i] <= gen;
                end
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    // ISA-level result of "op $2,$5,$6" (R-type) or "op $2,$5,imm" (I-type).
    function automatic logic [31:0] model(input int op, input logic [31:0] a, b,
                                          input logic [4:0] sh, input logic [15:0] im);
        logic [31:0] se, ze;
        se = {{16{im[15]}}, im};
        ze = {16'h0, im};
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6:  return (a < b) ? 32'd1 : 32'd0;
            7:  return b << sh;
            8:  return b >> sh;
            9:  return 32'($signed(b) >>> sh);
            10: return a + se;
            11: return a & ze;
            12: return a | ze;
            13: return a ^ ze;
            14: return ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            15: return (a < se) ? 32'd1 : 32'd0;
            default: return {im, 16'h0};
        endcase
    endfunction

    function automatic logic [31:0] enc(input int op, input logic [4:0] sh, input logic [15:0] im);
        logic [5:0] fn [10];
        logic [5:0] opc [7];
        fn  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        opc = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F};
        if (op < 10) return r_ins(5'd5, 5'd6, 5'd2, (op >= 7) ? sh : 5'd0, fn[op]);
        return i_ins(opc[op-10], (op == 16) ? 5'd0 : 5'd5, 5'd2, im);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
        gen++;
    endtask

    task automatic start_prog();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input string tag);
        int n;
        n = 0;
        while (active && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halt"}, {31'b0, active}, 32'd0);
    endtask

    localparam logic [31:0] JR0 = 32'h00000008;

    initial begin
        int base;
        int op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [15:0] im;

        reset = 1'b0;

        // ANDI program, also used for reset-state checks
        prog = '{i_ins(6'h0F, 0, 3, 16'h7777), i_ins(6'h0D, 3, 3, 16'h7777),
                 i_ins(6'h0C, 3, 2, 16'h3333), JR0, 32'h0};
        load_prog();
        wait_cycles = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_active", {31'b0, active}, 32'd1);
        check("rst_read", {31'b0, read}, 32'd0);
        check("rst_write", {31'b0, write}, 32'd0);
        check("rst_v0", register_v0, 32'd0);
        base = acc_addr.size();
        reset = 1'b1;
        run_to_halt("andi");
        check("andi_v0", register_v0, 32'h00003333);
        check("first_fetch_addr", (acc_addr.size() > base) ? acc_addr[base] : 32'hDEADBEEF, 32'hBFC00000);
        check("first_fetch_read", (acc_addr.size() > base) ? {31'b0, acc_read[base]} : 32'hDEADBEEF, 32'd1);

        prog = '{i_ins(6'h09, 0, 2, 16'hFFFF), JR0, 32'h0};
        load_prog();
        start_prog();
        run_to_halt("addiu");
        check("addiu_v0", register_v0, 32'hFFFFFFFF);

        prog = '{i_ins(6'h0F, 0, 4, 16'hBFC0), i_ins(6'h0D, 0, 2, 16'h1234),
                 i_ins(6'h2B, 4, 2, 16'h0100), i_ins(6'h09, 0, 2, 16'h0000),
                 i_ins(6'h23, 4, 2, 16'h0100), JR0, 32'h0};
        load_prog();
        start_prog();
        run_to_halt("ls");
        check("ls_mem", mem_view(32'hBFC00100), 32'h00001234);
        check("ls_v0", register_v0, 32'h00001234);
        check("ls_st_addr", last_st_addr, 32'hBFC00100);
        check("ls_st_data", last_st_data, 32'h00001234);
        check("byteenable", be_bad, 32'd0);

        prog = '{i_ins(6'h04, 0, 0, 16'h0002), i_ins(6'h09, 0, 2, 16'h0005),
                 i_ins(6'h09, 2, 2, 16'h0001), JR0, 32'h0};
        load_prog();
        start_prog();
        run_to_halt("beq");
        check("beq_v0", register_v0, 32'd5);

        // JAL to word 4; slot sets v0=1; target adds the link (0xBFC00008)
        prog = '{{6'h03, 26'(32'hBFC00010 >> 2)}, i_ins(6'h09, 0, 2, 16'h0001),
                 i_ins(6'h09, 2, 2, 16'h0100), 32'h0, r_ins(2, 31, 2, 0, 6'h21), JR0, 32'h0};
        load_prog();
        start_prog();
        run_to_halt("jal");
        check("jal_v0", register_v0, 32'hBFC00009);

        prog = '{i_ins(6'h0F, 0, 3, 16'h7777), i_ins(6'h0D, 3, 3, 16'h7777),
                 i_ins(6'h0C, 3, 2, 16'h3333), JR0, 32'h0};
        load_prog();
        wait_cycles = 3;
        start_prog();
        run_to_halt("wait");
        check("wait_v0", register_v0, 32'h00003333);
        check("wait_stable", stab_err, 32'd0);
        check("wait_stalled", {31'b0, stall_seen != 0}, 32'd1);
        wait_cycles = 0;

        // Reset pulse while the second instruction is in EXEC
        prog = '{i_ins(6'h09, 0, 2, 16'h0007), i_ins(6'h09, 2, 2, 16'h0001), JR0, 32'h0};
        load_prog();
        start_prog();
        base = acc_addr.size();
        for (int n = 0; n < 200 && acc_addr.size() < base + 2; n++) @(negedge clk);
        check("mid_reached", {31'b0, acc_addr.size() >= base + 2}, 32'd1);
        check("mid_v0_before", register_v0, 32'd7);
        @(negedge clk);
        reset = 1'b0;
        base = acc_addr.size();
        @(negedge clk);
        reset = 1'b1;
        check("mid_active", {31'b0, active}, 32'd1);
        check("mid_v0", register_v0, 32'd0);
        check("mid_read", {31'b0, read}, 32'd0);
        run_to_halt("mid");
        check("mid_fetch_addr", (acc_addr.size() > base) ? acc_addr[base] : 32'hDEADBEEF, 32'hBFC00000);
        check("mid_fetch_read", (acc_addr.size() > base) ? {31'b0, acc_read[base]} : 32'hDEADBEEF, 32'd1);
        check("mid_v0_final", register_v0, 32'd8);

        for (int t = 0; t < 24; t++) begin
            op = int'($urandom_range(0, 16));
            a  = $urandom;
            b  = (t % 5 == 0) ? a : $urandom;
            sh = 5'($urandom);
            im = 16'($urandom);
            prog = '{i_ins(6'h0F, 0, 5, a[31:16]), i_ins(6'h0D, 5, 5, a[15:0]),
                     i_ins(6'h0F, 0, 6, b[31:16]), i_ins(6'h0D, 6, 6, b[15:0]),
                     enc(op, sh, im), JR0, 32'h0};
            load_prog();
            wait_cycles = $urandom_range(0, 2);
            start_prog();
            run_to_halt($sformatf("rnd%0d", t));
            check($sformatf("rnd%0d_op%0d_v0", t, op), register_v0, model(op, a, b, sh, im));
        end

        check("no_fetch_zero", zero_fetch, 32'd0);
        check("no_rd_wr_both", both_err, 32'd0);
        check("stable_all", stab_err, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus.md
Name: mips_cpu_bus

Overview:
- Multicycle 32-bit MIPS-I subset CPU (big-endian word view) with a single Avalon-style memory-mapped master port shared by instruction fetch and data access.
- Starts at the reset vector 0xBFC00000 and runs until a jump to address 0, then halts and drops `active`.
- `register_v0` exposes GPR $2 continuously for test observation.
- Top-level processor block; memory and peripherals sit outside on the bus.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clk edge).
- active  output  1  high while CPU is running; low once halted.
- register_v0  output  32  current contents of GPR $2.
- address  output  32  byte address of the bus transaction; always word aligned.
- write  output  1  write request.
- read  output  1  read request.
- waitrequest  input  1  slave stall; the request is held unchanged while high.
- writedata  output  32  store data.
- byteenable  output  4  lane enables; 4'b1111 for all supported accesses.
- readdata  input  32  read data, valid one cycle after read acceptance.

Behaviour:
- Reset (reset==0 at clk edge):
  - PC=RESET_VECTOR; all 32 GPRs=0; state=FETCH.
  - active=1; read=0; write=0.
  - Reset mid-instruction aborts the instruction and discards any pending delay-slot target.
- Bus handshake:
  - A request (read or write, never both) is accepted on the edge where waitrequest==0.
  - address, writedata and byteenable stay stable until acceptance.
  - Read data is captured from readdata in the cycle after acceptance (read latency 1).
- State machine:
  - FETCH: read=1, address=PC; on acceptance go to DECODE.
  - DECODE: latch instruction from readdata; read register operands; go to EXEC.
  - EXEC: ALU op and branch/jump resolution. Loads/stores go to MEM; others go to WB.
  - MEM: read or write at the effective address; on acceptance, LW goes to LWB, SW goes to WB.
  - LWB: capture readdata into rt; go to WB.
  - WB: register write and PC update; go to FETCH, or to HALT if the new PC==0.
  - HALT: active=0, read=0, write=0; remain here until reset.
- PC and delay slots:
  - Branches and jumps have one architectural delay slot; the slot instruction always executes.
  - The taken target is stored as pending and applied after the delay-slot instruction completes.
  - Otherwise PC=PC+4.
  - Halt condition: the PC about to be fetched equals 0. `active` falls on the edge where the CPU would otherwise start that fetch, and no fetch from address 0 is issued.
- Register file:
  - $0 reads 0 always; writes to $0 are ignored.
  - Writes happen in WB only.
  - register_v0 reflects $2 combinationally from the register file.
- Instructions supported:
  - ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR
  - ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI
  - LW, SW, BEQ, BNE, J, JAL
- Arithmetic and immediates:
  - ANDI, ORI, XORI zero-extend imm16.
  - ADDIU, SLTI, SLTIU, loads/stores and branch offsets sign-extend imm16.
  - All adds wrap modulo 2^32; there are no overflow exceptions.
  - Branch target = (PC+4) + (sext(imm16)<<2).
  - J and JAL target = {PC+4[31:28], target26, 2'b00}.
  - JAL and JALR link PC+8 into $31 and rd respectively.
- Unsupported opcodes execute as NOP (PC+4, no writes).
- Misaligned LW/SW addresses are forced word aligned by clearing address[1:0].

Test Plan:
- ANDI: LUI $3,0x7777; ORI $3,$3,0x7777; ANDI $2,$3,0x3333; JR $0; NOP → active falls; register_v0==32'h00003333.
- ADDIU sign-extend: ADDIU $2,$0,0xFFFF; JR $0; NOP → register_v0==32'hFFFFFFFF.
- Load/store: LUI $4,0xBFC0; ORI $2,$0,0x1234; SW $2,0x100($4); ADDIU $2,$0,0; LW $2,0x100($4); JR $0; NOP:
  - memory word 0xBFC00100 becomes 0x00001234;
  - register_v0==0x00001234;
  - byteenable==4'b1111 on both accesses.
- Branch delay slot: BEQ $0,$0,+2 with ADDIU $2,$0,5 in the slot, and ADDIU $2,$2,1 at the skipped address → register_v0==5.
- Wait states: hold waitrequest high 3 cycles on every request while running the ANDI program → same final v0; address and read stable while stalled.
- Reset mid-run: pulse reset low for 1 cycle during EXEC → next transaction is a fetch from 0xBFC00000, register_v0==0, active==1.
